// File: rtl/lcd_pattern_gen_if.sv
// ----------------------------------------------------------------------------
// lcd_pattern_gen_if
//
// Pixel-stream bundle between the LCD timing generator, the pattern
// generator and the RGB565 panel pins.
//
// Handshake: den_in is the valid. A pixel (xpos, ypos) is taken on every clk
// edge where den_in=1; there is no ready, because the panel cannot stall.
// den_out is the matching valid on the output side, two clk cycles later.
//
// Signals:
//   hsync_in, vsync_in, den_in : timing from the timing generator
//   xpos, ypos                 : pixel coordinates, meaningful while den_in=1
//   hsync_out, vsync_out       : sync re-timed to line up with the colour
//   den_out                    : data enable re-timed with the colour
//   lcd_r, lcd_g, lcd_b        : RGB565 colour to the panel
//
// Modports:
//   master : timing-generator / bench side (drives *_in, reads *_out)
//   slave  : pattern generator side
// ----------------------------------------------------------------------------
interface lcd_pattern_gen_if;
    logic       hsync_in;
    logic       vsync_in;
    logic       den_in;
    logic [9:0] xpos;
    logic [9:0] ypos;
    logic       hsync_out;
    logic       vsync_out;
    logic       den_out;
    logic [4:0] lcd_r;
    logic [5:0] lcd_g;
    logic [4:0] lcd_b;

    modport master (
        output hsync_in, vsync_in, den_in, xpos, ypos,
        input  hsync_out, vsync_out, den_out, lcd_r, lcd_g, lcd_b
    );

    modport slave (
        input  hsync_in, vsync_in, den_in, xpos, ypos,
        output hsync_out, vsync_out, den_out, lcd_r, lcd_g, lcd_b
    );
endinterface

// File: rtl/lcd_pattern_gen.sv
// ----------------------------------------------------------------------------
// lcd_pattern_gen
//
// Test-pattern generator sitting between the LCD timing generator and the
// RGB565 panel pins, clocked by the pixel clock. Five patterns (checker,
// colour bars, gradient, solid, bouncing box) are cycled by a debounced
// BTN_USER press; the switch is applied only at frame start so a frame
// never tears. Sync and DEN go through the same two-stage pipeline as the
// colour.
//
// Ports:
//   clk          : pixel clock
//   BTN_RESET    : asynchronous active-low reset
//   btn_user     : raw user button, active-low, asynchronous to clk
//   lcd          : pixel-stream interface (slave side)
//   mode         : pattern currently displayed
//   frame_count  : free-running frame counter
//   box_x/box_y  : bouncing-box position (debug view of the motion state)
//   box_dx/dy    : bouncing-box direction, 1 = increasing
// ----------------------------------------------------------------------------
module lcd_pattern_gen #(
    parameter int          H_ACTIVE        = 480,
    parameter int          V_ACTIVE        = 272,
    parameter int          TILE_LOG2       = 5,
    parameter int          DEBOUNCE_CYCLES = 90000,
    parameter int          NUM_MODES       = 5,
    parameter logic [15:0] SOLID_RGB       = 16'hF00F,
    parameter int          BOX_SIZE        = 32,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               BTN_RESET,
    input  logic               btn_user,
    lcd_pattern_gen_if.slave   lcd,
    output logic [2:0]         mode,
    output logic [7:0]         frame_count,
    output logic [9:0]         box_x,
    output logic [9:0]         box_y,
    output logic               box_dx,
    output logic               box_dy
);

    localparam logic            SYNC_IDLE = SYNC_ACTIVE_LOW;
    localparam int              T         = TILE_LOG2;
    localparam int              DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [9:0]      BX_MAX    = 10'(H_ACTIVE - BOX_SIZE);
    localparam logic [9:0]      BY_MAX    = 10'(V_ACTIVE - BOX_SIZE);
    localparam logic [2:0]      MODE_LAST = 3'(NUM_MODES - 1);

    // Button path
    logic            btn_s1_q, btn_s1_d;
    logic            btn_s2_q, btn_s2_d;
    logic            btn_acc_q, btn_acc_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            pending_q, pending_d;
    logic            press;

    // Frame-rate state
    logic [2:0]      mode_q, mode_d;
    logic [7:0]      frame_cnt_q, frame_cnt_d;
    logic [9:0]      bx_q, bx_d, by_q, by_d;
    logic            dx_q, dx_d, dy_q, dy_d;
    logic            frame_start;

    // Pipeline
    logic [9:0]      x1_q, x1_d, y1_q, y1_d;
    logic            den1_q, den1_d, hs1_q, hs1_d, vs1_q, vs1_d;
    logic [15:0]     rgb2_q, rgb2_d;
    logic            den2_q, den2_d, hs2_q, hs2_d, vs2_q, vs2_d;

    logic [15:0]     colour;
    logic [2:0]      bar;
    logic            in_box;

    // vs2_q is the previous stage-1 vsync, so this is the inactive->active
    // edge of the stage-1 register. Both reset to idle, so no edge is seen
    // until a real one arrives after reset release.
    assign frame_start = (vs1_q != SYNC_IDLE) && (vs2_q == SYNC_IDLE);

    // Accepted level falling 1->0 is a press.
    assign press = btn_acc_q && !btn_acc_d;

    always_comb begin
        btn_s1_d    = btn_user;
        btn_s2_d    = btn_s1_q;
        btn_acc_d   = btn_acc_q;
        db_cnt_d    = db_cnt_q;
        pending_d   = pending_q;
        mode_d      = mode_q;
        frame_cnt_d = frame_cnt_q;
        bx_d        = bx_q;
        by_d        = by_q;
        dx_d        = dx_q;
        dy_d        = dy_q;

        // Counter runs only while the synchronised level disagrees with the
        // accepted one; any return to agreement restarts it.
        if (btn_s2_q == btn_acc_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            btn_acc_d = btn_s2_q;
            db_cnt_d  = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end

        if (frame_start) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            if (pending_q) begin
                mode_d = (mode_q == MODE_LAST) ? 3'd0 : mode_q + 3'd1;
            end
            // A press landing on this very cycle survives for the next frame.
            pending_d = press;

            if (dx_q && bx_q == BX_MAX) begin
                dx_d = 1'b0;
                bx_d = bx_q - 10'd1;
            end else if (!dx_q && bx_q == 10'd0) begin
                dx_d = 1'b1;
                bx_d = 10'd1;
            end else begin
                bx_d = dx_q ? bx_q + 10'd1 : bx_q - 10'd1;
            end

            if (dy_q && by_q == BY_MAX) begin
                dy_d = 1'b0;
                by_d = by_q - 10'd1;
            end else if (!dy_q && by_q == 10'd0) begin
                dy_d = 1'b1;
                by_d = 10'd1;
            end else begin
                by_d = dy_q ? by_q + 10'd1 : by_q - 10'd1;
            end
        end else if (press) begin
            pending_d = 1'b1;
        end
    end

    // Colour for the pixel currently in stage 1.
    always_comb begin
        colour = 16'h0000;
        bar    = 3'd0;
        in_box = 1'b0;

        // Bar index without a divider: count the bar boundaries already passed.
        for (int k = 1; k < 8; k++) begin
            if ({1'b0, x1_q} >= 11'(k * H_ACTIVE / 8)) begin
                bar = bar + 3'd1;
            end
        end

        in_box = ({1'b0, x1_q} >= {1'b0, bx_q}) &&
                 ({1'b0, x1_q} <  {1'b0, bx_q} + 11'(BOX_SIZE)) &&
                 ({1'b0, y1_q} >= {1'b0, by_q}) &&
                 ({1'b0, y1_q} <  {1'b0, by_q} + 11'(BOX_SIZE));

        case (mode_q)
            3'd0: colour = {{5{x1_q[T]   ^ y1_q[T]}},
                            {6{x1_q[T+1] ^ y1_q[T+1]}},
                            {5{x1_q[T+2] ^ y1_q[T+2]}}};
            3'd1: colour = {{5{~bar[1]}}, {6{~bar[2]}}, {5{~bar[0]}}};
            3'd2: colour = {x1_q[8:4], y1_q[8:3], frame_cnt_q[7:3]};
            3'd3: colour = SOLID_RGB;
            3'd4: colour = in_box ? 16'hFFFF : 16'h001F;
            default: colour = 16'h0000;
        endcase
    end

    always_comb begin
        x1_d   = lcd.xpos;
        y1_d   = lcd.ypos;
        den1_d = lcd.den_in;
        hs1_d  = lcd.hsync_in;
        vs1_d  = lcd.vsync_in;
        rgb2_d = den1_q ? colour : 16'h0000;
        den2_d = den1_q;
        hs2_d  = hs1_q;
        vs2_d  = vs1_q;
    end

    always_ff @(posedge clk or negedge BTN_RESET) begin
        if (!BTN_RESET) begin
            btn_s1_q    <= 1'b1;
            btn_s2_q    <= 1'b1;
            btn_acc_q   <= 1'b1;
            db_cnt_q    <= '0;
            pending_q   <= 1'b0;
            mode_q      <= 3'd0;
            frame_cnt_q <= 8'd0;
            bx_q        <= 10'd0;
            by_q        <= 10'd0;
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
            x1_q        <= 10'd0;
            y1_q        <= 10'd0;
            den1_q      <= 1'b0;
            hs1_q       <= SYNC_IDLE;
            vs1_q       <= SYNC_IDLE;
            rgb2_q      <= 16'h0000;
            den2_q      <= 1'b0;
            hs2_q       <= SYNC_IDLE;
            vs2_q       <= SYNC_IDLE;
        end else begin
            btn_s1_q    <= btn_s1_d;
            btn_s2_q    <= btn_s2_d;
            btn_acc_q   <= btn_acc_d;
            db_cnt_q    <= db_cnt_d;
            pending_q   <= pending_d;
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            den1_q      <= den1_d;
            hs1_q       <= hs1_d;
            vs1_q       <= vs1_d;
            rgb2_q      <= rgb2_d;
            den2_q      <= den2_d;
            hs2_q       <= hs2_d;
            vs2_q       <= vs2_d;
        end
    end

    assign lcd.hsync_out = hs2_q;
    assign lcd.vsync_out = vs2_q;
    assign lcd.den_out   = den2_q;
    assign lcd.lcd_r     = rgb2_q[15:11];
    assign lcd.lcd_g     = rgb2_q[10:5];
    assign lcd.lcd_b     = rgb2_q[4:0];
    assign mode          = mode_q;
    assign frame_count   = frame_cnt_q;
    assign box_x         = bx_q;
    assign box_y         = by_q;
    assign box_dx        = dx_q;
    assign box_dy        = dy_q;

endmodule
